sumador_acc: RTL
================

# sumador_acc

Parametrised accumulating adder, the successor to the fixed 8-bit `sumador` accumulator used behind the `tt_um_` top-level wrappers. It adds a configurable data width, four operations, selectable wrap or saturate arithmetic, a sticky overflow flag and a registered target-match pulse. The block sits directly under the top-level pin wrapper:

- Control and operand come from `ui_in`/`uio_in`.
- `out` drives `uo_out`.
- Status bits drive `uio_out`.

## Interface

Parameters:
- `WIDTH`, default 8: accumulator and operand width in bits, legal range 2..32.
- `RESET_VAL`, default 0: value loaded into `out` on reset. Must fit in `WIDTH` bits.

Ports:
- `clk`  in  1  single clock; all state changes on its rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `enable`  in  1  when 1, the operation on `op` executes at this rising edge; when 0, the accumulator holds.
- `op`  in  2  operation select: 00 ADD, 01 SUB, 10 LOAD, 11 CLEAR.
- `operand`  in  WIDTH  unsigned operand for ADD/SUB/LOAD.
- `sat`  in  1  1 = saturate on carry/borrow; 0 = wrap modulo 2^WIDTH. Sampled with `enable`.
- `target`  in  WIDTH  compare value for `hit`.
- `clr_ovf`  in  1  synchronous clear of the sticky `ovf`.
- `out`  out  WIDTH  accumulator register.
- `cout`  out  1  registered carry (ADD) or borrow (SUB) of the last executed edge.
- `ovf`  out  1  sticky overflow flag.
- `zero`  out  1  `out == 0`, decoded combinationally from the `out` register.
- `hit`  out  1  registered one-cycle pulse, set when the newly written `out` equals `target`.

## Operation

- Arithmetic is unsigned, computed at WIDTH+1 bits. Bit WIDTH is the carry/borrow.
- **ADD:**
  - Result is `out + operand`.
  - On carry with `sat`=1: `out` ← all ones.
  - On carry with `sat`=0: `out` ← low WIDTH bits.
- **SUB:**
  - Result is `out - operand`.
  - On borrow (operand > out) with `sat`=1: `out` ← 0.
  - On borrow with `sat`=0: `out` ← low WIDTH bits (two's-complement wrap).
- **LOAD:** `out` ← `operand`; `cout` ← 0.
- **CLEAR:** `out` ← 0; `cout` ← 0. `ovf` is not affected.
- **`cout`:**
  - Equals the carry/borrow of the executed ADD/SUB, in both `sat` modes.
  - Forced to 0 on any edge with `enable`=0 or `op` LOAD/CLEAR, so it is a one-cycle pulse per event.
- **`ovf`:**
  - Set on any edge where `cout` is set.
  - Cleared by `clr_ovf`=1.
  - Set and clear on the same edge: set wins.
  - Independent of `enable` for the clear path.
- **`hit`:**
  - 1 for the cycle following any enabled edge whose written `out` value equals `target`, including LOAD/CLEAR.
  - 0 after non-enabled edges, even if `out` still equals `target`.
- `zero` tracks the `out` register at all times, including during reset.

## Timing

- **Reset:** asynchronous assertion of `rst_n`=0 immediately forces:
  - `out`=`RESET_VAL`, `cout`=0, `ovf`=0, `hit`=0.
  - `zero` follows (1 iff `RESET_VAL`=0).
- Reset asserted mid-operation overrides any op in flight. Deassertion is taken synchronously by the wrapper; the first operation executes at the first rising edge with `rst_n`=1 and `enable`=1.
- **Latency:** 1 cycle. Inputs are sampled at edge N; `out`, `cout`, `hit` and `ovf` are valid after edge N.
- **Throughput:** one operation per cycle. Back-to-back enabled ops chain on the previous `out` with no bubbles.
- **No handshake:** `enable` is a level qualifier. Inputs must be stable around the rising edge; changes with `enable`=0 have no effect except on `clr_ovf`.
- **Boundaries:**
  - ADD of 0 never carries.
  - SUB of 0 never borrows.
  - SUB with operand == out gives 0 with no borrow.
  - Saturated ADD at all-ones with operand>0 holds all-ones and pulses `cout` every cycle.

## Test plan

All scenarios use WIDTH=8 and RESET_VAL=0.

1. **Reset:** drive rst_n=0 mid-stream with out=0x5A and ovf=1 → immediately out=0x00, cout=0, ovf=0, hit=0, zero=1; after release with enable=0, all outputs hold.
2. **Wrap ADD:** LOAD 0xF0, then ADD 0x20 with sat=0 → out=0x10, cout=1 for one cycle, ovf=1 and stays 1 after three idle cycles.
3. **Saturating ADD/SUB:**
   - LOAD 0xF0, ADD 0x20 with sat=1 → out=0xFF, cout=1.
   - Then SUB 0xFF → out=0x00, cout=0.
   - Then SUB 0x01 → out=0x00, cout=1.
4. **Wrap SUB:** LOAD 0x03, SUB 0x05 with sat=0 → out=0xFE, cout=1; then ADD 0x02 → out=0x00, cout=1, zero=1.
5. **Sticky flag priority:**
   - With ovf=1, assert clr_ovf together with an overflowing ADD → ovf stays 1.
   - Next cycle assert clr_ovf alone with enable=0 → ovf=0.
6. **Hit pulse:**
   - target=0x07, ADD 0x01 from 0x05 on four consecutive cycles → hit=1 only after the edge writing 0x07.
   - Then CLEAR with target=0x00 → hit=1 for one cycle, 0 on the following idle cycle.

Source files
------------

// File: rtl/sumador_acc.sv
// Accumulating adder (ADD/SUB/LOAD/CLEAR, wrap or saturate) with sticky overflow and target-match pulse.
// Latency 1 cycle, one op per enabled cycle; no backpressure, enable is a plain level qualifier.
module sumador_acc #(
  parameter int unsigned          WIDTH     = 8,
  parameter logic [WIDTH-1:0]     RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] operand,
  input  logic             sat,
  input  logic [WIDTH-1:0] target,
  input  logic             clr_ovf,
  output logic [WIDTH-1:0] out,
  output logic             cout,
  output logic             ovf,
  output logic             zero,
  output logic             hit
);

  typedef enum logic [1:0] {
    OP_ADD   = 2'b00,
    OP_SUB   = 2'b01,
    OP_LOAD  = 2'b10,
    OP_CLEAR = 2'b11
  } op_e;

  logic [WIDTH-1:0] out_q, out_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             hit_q, hit_d;

  logic [WIDTH:0]   sum_w;
  logic [WIDTH:0]   diff_w;

  // Bit WIDTH of each result is the carry (ADD) or borrow (SUB).
  assign sum_w  = {1'b0, out_q} + {1'b0, operand};
  assign diff_w = {1'b0, out_q} - {1'b0, operand};

  always_comb begin
    out_d  = out_q;
    cout_d = 1'b0;
    hit_d  = 1'b0;
    ovf_d  = ovf_q & ~clr_ovf;

    if (enable) begin
      unique case (op_e'(op))
        OP_ADD: begin
          cout_d = sum_w[WIDTH];
          out_d  = (sum_w[WIDTH] && sat) ? {WIDTH{1'b1}} : sum_w[WIDTH-1:0];
        end
        OP_SUB: begin
          cout_d = diff_w[WIDTH];
          out_d  = (diff_w[WIDTH] && sat) ? {WIDTH{1'b0}} : diff_w[WIDTH-1:0];
        end
        OP_LOAD:  out_d = operand;
        OP_CLEAR: out_d = '0;
        default:  out_d = out_q;
      endcase
      hit_d = (out_d == target);
    end

    // A new overflow event beats a simultaneous clear.
    if (cout_d) begin
      ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q  <= RESET_VAL;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
      hit_q  <= 1'b0;
    end else begin
      out_q  <= out_d;
      cout_q <= cout_d;
      ovf_q  <= ovf_d;
      hit_q  <= hit_d;
    end
  end

  assign out  = out_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;
  assign hit  = hit_q;
  assign zero = (out_q == '0);

endmodule
